seven_segment_scanner: RTL
==========================

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the number of multiplexed digits (1..8).
REQ-002 Parameter REFRESH_DIV, default 50000, SHALL set the number of clocks each digit is held (>=2).
REQ-003 Parameter ACTIVE_LOW, default 0, SHALL invert Segments and DigitSel when 1.
REQ-004 Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 ResetN  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 Value  input  4*DIGITS  SHALL be hex nibbles; nibble k drives digit k, digit 0 least significant.
REQ-007 Load  input  1  SHALL, when high at an edge, capture Value into the pending register.
REQ-008 Enable  input  1  SHALL drive all Segments and DigitSel inactive when low.
REQ-009 DigitBlank  input  DIGITS  SHALL force digit k's segments inactive when bit k is high.
REQ-010 ZeroSuppress  input  1  SHALL enable leading-zero blanking when high.
REQ-011 Segments  output  7  SHALL be the registered segment pattern, bit order gfedcba, bit 0 = a.
REQ-012 DigitSel  output  DIGITS  SHALL be the registered one-hot digit select.
REQ-013 FrameDone  output  1  SHALL be a registered one-cycle pulse at each frame wrap.

Function
REQ-014 The prescaler SHALL count 0..REFRESH_DIV-1 and then wrap to 0; tick = (prescaler == REFRESH_DIV-1).
REQ-015 On tick, the digit index SHALL advance by 1 and wrap from DIGITS-1 to 0 ("frame wrap").
REQ-016 Load SHALL write pending <= Value and set pending_valid on the same edge.
REQ-017 On frame wrap with pending_valid set, shown SHALL become pending and pending_valid SHALL clear.
REQ-018 Load coincident with frame wrap SHALL make shown = Value directly and leave pending_valid clear.
REQ-019 Segments and DigitSel SHALL update on every edge from the next index and next shown; they change on the same edge the index advances, with no extra latency.
REQ-020 Nibble decode SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71 (hex).
REQ-021 ZeroSuppress SHALL blank digit k (k>=1) when nibble k and all higher nibbles of shown are 0; digit 0 SHALL never be suppressed.
REQ-022 Blank priority SHALL be: Enable low > DigitBlank[k] > zero suppression > decode.
REQ-023 An inactive segment or select SHALL be 0 when ACTIVE_LOW=0 and 1 when ACTIVE_LOW=1; an active one SHALL be the opposite level.
REQ-024 A blanked digit SHALL still assert DigitSel with all segments inactive; only Enable low deasserts DigitSel.
REQ-025 Prescaler, index and FrameDone SHALL keep running while Enable is low.
REQ-026 FrameDone SHALL be high for exactly the one cycle following the frame-wrap edge, once per DIGITS*REFRESH_DIV clocks.

Reset
REQ-027 ResetN low SHALL immediately clear the prescaler, index, pending, pending_valid, shown and FrameDone, and drive Segments and DigitSel to the inactive level.
REQ-028 A reset asserted mid-frame or mid-Load SHALL discard any pending value.
REQ-029 On the first edge after ResetN rises, DigitSel SHALL select digit 0 and Segments SHALL show the decode of 0 (or blank, per REQ-022).

Verification (DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=0 unless noted)
REQ-030 Reset, then Load with Value=16'h12AF -> display stays 0 until the first frame wrap; after it, digits 0..3 show Segments 71,77,5B,06 on successive 4-cycle slots.
REQ-031 ZeroSuppress=1 with Value=16'h0005 -> digits 3..1 blank and digit 0 shows 6D; with Value=16'h0000 only digit 0 shows 3F.
REQ-032 Enable=0 for 40 cycles -> Segments=00 and DigitSel=0 throughout; FrameDone still pulses every 16 cycles.
REQ-033 ACTIVE_LOW=1 -> during reset Segments=7F and DigitSel=F; nibble 8 on digit 2 -> Segments=00 and DigitSel=4'b1011.
REQ-034 ResetN pulsed low while index=2 with pending_valid set -> outputs go inactive without waiting for a clock; after release digit 0 shows 3F and the old pending value never appears.
REQ-035 Load with Value=16'h0007 on the frame-wrap edge -> digit 0 shows 07 on that same edge; pending_valid=0.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment driver: scans DIGITS hex digits, one per REFRESH_DIV clocks,
// with double-buffered value updates at frame boundaries, blanking and leading-zero suppression.
module seven_segment_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit ACTIVE_LOW  = 1'b0
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    input  logic [4*DIGITS-1:0]   Value,
    input  logic                  Load,
    input  logic                  Enable,
    input  logic [DIGITS-1:0]     DigitBlank,
    input  logic                  ZeroSuppress,
    output logic [6:0]            Segments,
    output logic [DIGITS-1:0]     DigitSel,
    output logic                  FrameDone
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] LAST_PRE = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    logic [PW-1:0]         r_prescaler;
    logic [IW-1:0]         r_index;
    logic [4*DIGITS-1:0]   r_pending;
    logic                  r_pendingValid;
    logic [4*DIGITS-1:0]   r_shown;
    logic [6:0]            r_segments;
    logic [DIGITS-1:0]     r_digitSel;
    logic                  r_frameDone;

    logic                  w_tick;
    logic                  w_wrap;
    logic [PW-1:0]         w_prescalerNext;
    logic [IW-1:0]         w_indexNext;
    logic [4*DIGITS-1:0]   w_shownNext;
    logic [3:0]            w_nibble;
    logic                  w_upperZero;
    logic                  w_suppress;
    logic                  w_blank;
    logic [DIGITS-1:0]     w_selNext;
    logic [6:0]            w_segActive;
    logic [DIGITS-1:0]     w_selActive;

    function automatic logic [6:0] decodeNibble(input logic [3:0] nib);
        case (nib)
            4'h0: decodeNibble = 7'h3F;
            4'h1: decodeNibble = 7'h06;
            4'h2: decodeNibble = 7'h5B;
            4'h3: decodeNibble = 7'h4F;
            4'h4: decodeNibble = 7'h66;
            4'h5: decodeNibble = 7'h6D;
            4'h6: decodeNibble = 7'h7D;
            4'h7: decodeNibble = 7'h07;
            4'h8: decodeNibble = 7'h7F;
            4'h9: decodeNibble = 7'h6F;
            4'hA: decodeNibble = 7'h77;
            4'hB: decodeNibble = 7'h7C;
            4'hC: decodeNibble = 7'h39;
            4'hD: decodeNibble = 7'h5E;
            4'hE: decodeNibble = 7'h79;
            default: decodeNibble = 7'h71;
        endcase
    endfunction

    // Outputs are built from the post-edge index and shown value so they move with the index.
    always_comb begin
        w_tick          = (r_prescaler == LAST_PRE);
        w_wrap          = w_tick && (r_index == LAST_IDX);
        w_prescalerNext = w_tick ? '0 : r_prescaler + PW'(1);
        w_indexNext     = r_index;
        if (w_tick) begin
            w_indexNext = w_wrap ? '0 : r_index + IW'(1);
        end

        w_shownNext = r_shown;
        if (w_wrap) begin
            if (Load) begin
                w_shownNext = Value;
            end else if (r_pendingValid) begin
                w_shownNext = r_pending;
            end
        end

        w_nibble    = 4'h0;
        w_upperZero = 1'b1;
        w_suppress  = 1'b0;
        w_blank     = 1'b0;
        w_selNext   = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_upperZero  = w_upperZero && (w_shownNext[4*k +: 4] == 4'h0);
            w_selNext[k] = (w_indexNext == IW'(k));
            if (w_indexNext == IW'(k)) begin
                w_nibble   = w_shownNext[4*k +: 4];
                w_suppress = w_upperZero && (k != 0);
                w_blank    = DigitBlank[k];
            end
        end

        w_segActive = (!Enable || w_blank || (ZeroSuppress && w_suppress)) ? 7'h00
                                                                            : decodeNibble(w_nibble);
        w_selActive = Enable ? w_selNext : '0;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_prescaler    <= '0;
            r_index        <= '0;
            r_pending      <= '0;
            r_pendingValid <= 1'b0;
            r_shown        <= '0;
            r_segments     <= {7{ACTIVE_LOW}};
            r_digitSel     <= {DIGITS{ACTIVE_LOW}};
            r_frameDone    <= 1'b0;
        end else begin
            r_prescaler <= w_prescalerNext;
            r_index     <= w_indexNext;
            r_shown     <= w_shownNext;
            if (Load) begin
                r_pending <= Value;
            end
            // A wrap always consumes or discards the pending flag, even with a coincident Load.
            if (w_wrap) begin
                r_pendingValid <= 1'b0;
            end else if (Load) begin
                r_pendingValid <= 1'b1;
            end
            r_segments  <= w_segActive ^ {7{ACTIVE_LOW}};
            r_digitSel  <= w_selActive ^ {DIGITS{ACTIVE_LOW}};
            r_frameDone <= w_wrap;
        end
    end

    assign Segments  = r_segments;
    assign DigitSel  = r_digitSel;
    assign FrameDone = r_frameDone;

endmodule
